// File: rtl/stream_demux4.sv
// One-to-four registered stream demux; one holding register per port so a stalled port never blocks the others.
// Latency 1 cycle to the port; in_ready is combinational from in_sel/out_ready; per-port saturating drain counters.
module stream_demux4 #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [1:0]           in_sel,
  output logic [3:0]           out_valid,
  input  logic [3:0]           out_ready,
  output logic [4*WIDTH-1:0]   out_data,
  output logic [4*CNT_W-1:0]   out_count,
  input  logic                 clr_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [3:0]       r_hold_valid;
  logic [WIDTH-1:0] r_hold_data [4];
  logic [CNT_W-1:0] r_count [4];

  logic [3:0] w_drain;
  logic [3:0] w_load;
  logic       w_xfer;

  assign w_drain = r_hold_valid & out_ready;

  // A full port may still accept when its consumer is taking the old word this cycle.
  assign in_ready = ~r_hold_valid[in_sel] | out_ready[in_sel];
  assign w_xfer   = in_valid & in_ready;

  always_comb begin
    w_load         = '0;
    w_load[in_sel] = w_xfer;
  end

  assign out_valid = r_hold_valid;

  for (genvar g = 0; g < 4; g++) begin : g_port
    assign out_data[g*WIDTH +: WIDTH]  = r_hold_data[g];
    assign out_count[g*CNT_W +: CNT_W] = r_count[g];

    always_ff @(posedge clk) begin
      if (!reset) begin
        r_hold_valid[g] <= 1'b0;
        r_hold_data[g]  <= '0;
      end else if (w_load[g]) begin
        r_hold_valid[g] <= 1'b1;
        r_hold_data[g]  <= in_data;
      end else if (w_drain[g]) begin
        r_hold_valid[g] <= 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (!reset || clr_count) begin
        r_count[g] <= '0;
      end else if (w_drain[g] && (r_count[g] != CNT_MAX)) begin
        r_count[g] <= r_count[g] + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/stream_demux4.md
# stream_demux4

One-to-four registered stream demultiplexer: accepts a single valid/ready input stream tagged with a 2-bit destination select and delivers each word to exactly one of four output ports. Each output port has its own one-entry holding register, so a stalled port does not block words bound for other ports. It is the distribution counterpart of the datapath's 2:1 / 4:1 selectors. It is used wherever one producer, such as write-back or forwarding data, fans out to several independent consumers that apply their own backpressure.

## Interface
Parameters:
- WIDTH, 64, data word width in bits.
- CNT_W, 8, width of each per-port delivered-word counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- in_valid  in  1  input word present.
- in_ready  out  1  block can accept the input word this cycle.
- in_data  in  WIDTH  input word.
- in_sel  in  2  destination port, 0..3.
- out_valid  out  4  bit k: port k holds a word.
- out_ready  in  4  bit k: consumer k takes the word this cycle.
- out_data  out  4*WIDTH  port k data is bits [k*WIDTH +: WIDTH].
- out_count  out  4*CNT_W  port k count of words delivered to consumer k, at bits [k*CNT_W +: CNT_W]; saturates.
- clr_count  in  1  synchronous clear of all four counters.

## Operation
- Each port k has a holding register with two fields: hold_valid[k] and hold_data[k]. out_valid[k] = hold_valid[k]. out_data slice k = hold_data[k].
- Drain condition: drain[k] = hold_valid[k] & out_ready[k].
- Acceptance rule:
  - in_ready = ~hold_valid[in_sel] | out_ready[in_sel].
  - in_ready is combinational from in_sel, hold_valid and out_ready. It does not depend on in_valid.
- Input transfer: occurs when in_valid & in_ready.
- Per-port update at each edge, in priority order:
  - If port k receives an input transfer (in_sel == k), then hold_data[k] <= in_data and hold_valid[k] <= 1. This also applies when drain[k] happens in the same cycle: the old word leaves and the new word is loaded.
  - Else, if drain[k], then hold_valid[k] <= 0.
  - Otherwise the register holds its value.
- Data in a full, undrained holding register never changes.
- A port's state is never affected by a transfer addressed to another port.
- Counter rules:
  - out_count[k] increments by 1 on each drain[k].
  - It holds at 2^CNT_W-1 once it reaches that value. It does not wrap.
  - clr_count forces all counters to 0 and takes priority over an increment in the same cycle.
- Word accounting: each accepted word is delivered exactly once. No word is duplicated or dropped.
- Reset (reset == 0 at an edge):
  - hold_valid = 0, hold_data = 0, out_count = 0.
  - A word held mid-transfer is discarded.
  - in_ready is not forced low during reset. It follows the acceptance rule. Any input transfer in a reset cycle is ignored.
- Reset output values: out_valid = 4'b0000, out_data = 0, out_count = 0, in_ready = 1.
- in_sel is don't-care when in_valid = 0.

## Timing
- Latency: a word accepted at edge n is visible on out_valid/out_data of its port after edge n. It is consumable in cycle n+1.
- Throughput: 1 word per cycle to any single port, provided its consumer holds out_ready high.
- Back-to-back transfers to different ports require no idle cycles.
- Combinational paths:
  - in_ready is combinational from out_ready and in_sel, with no register on this path.
  - No combinational path exists from in_data to out_data.
- Full port: hold_valid[k] = 1 and out_ready[k] = 0 forces in_ready = 0 whenever in_sel = k. The producer must hold in_valid, in_data and in_sel stable until accepted.
- Simultaneous events:
  - Load and drain on the same port in the same cycle: the new word replaces the old one and out_valid stays 1.
  - Drain on port j and load on port k (j ≠ k) in the same cycle are independent.

## Test plan
- **Reset:** drive reset = 0 for 2 cycles with in_valid = 1, in_sel = 2.
  - Response: out_valid = 0000, all counts 0, in_ready = 1.
  - After release, the first transfer lands only on port 2.
- **Routing:** with out_ready = 1111, send 0xA0, 0xA1, 0xA2, 0xA3 to sel 0, 1, 2, 3 on consecutive cycles.
  - Response: each word appears on its own port exactly one cycle after acceptance.
  - Each out_count ends at 1.
- **Backpressure isolation:** hold out_ready[1] = 0 and load 0x11 to port 1.
  - Then send 0x22 to port 1: in_ready must be 0 and port 1 keeps 0x11.
  - Then send 0x33 to port 3: in_ready = 1 and 0x33 appears on port 3.
- **Load and drain same cycle:** port 0 holds 0x55 with out_ready[0] = 1, and in_valid = 1, sel 0, data 0x66 in the same cycle.
  - Response: 0x55 is consumed and 0x66 is present the next cycle.
  - out_valid[0] stays 1 and count(0) increments by 1.
- **Counter saturation and clear:** with CNT_W = 8, drain 260 words on port 2.
  - Response: count(2) = 255.
  - Then assert clr_count together with a drain: count(2) = 0 next cycle.
- **Reset mid-operation:** all four ports full and stalled, then assert reset = 0 for one edge.
  - Response: out_valid = 0000 and counts 0 next cycle.
  - No held word reappears after reset is released.
